// File: rtl/prog_loader_if.sv
// Loader byte stream and processor memory port bundle for prog_loader.
// master drives loader bytes and CPU accesses, slave is the loader block.
interface prog_loader_if #(
  parameter int DEPTH_LOG2 = 8
);
  logic                  load_valid;
  logic [7:0]            load_data;
  logic                  load_last;
  logic                  load_ready;
  logic [15:0]           cpu_addr;
  logic                  cpu_we;
  logic [15:0]           cpu_wdata;
  logic [15:0]           cpu_rdata;
  logic                  cpu_rst;
  logic                  done;
  logic                  err;
  logic [DEPTH_LOG2:0]   word_count;

  modport master (
    output load_valid, load_data, load_last,
    output cpu_addr, cpu_we, cpu_wdata,
    input  load_ready, cpu_rdata, cpu_rst,
    input  done, err, word_count
  );

  modport slave (
    input  load_valid, load_data, load_last,
    input  cpu_addr, cpu_we, cpu_wdata,
    output load_ready, cpu_rdata, cpu_rst,
    output done, err, word_count
  );
endinterface

// File: rtl/prog_loader.sv
// Byte-stream program loader into a 16-bit word RAM that then serves the CPU.
// Optional checksum byte after the program: define LOADER_CSUM_EN.
module prog_loader #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic         clk,
  input  logic         rst,
  prog_loader_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL =
    {1'b1, {DEPTH_LOG2{1'b0}}};

`ifdef LOADER_CSUM_EN
  typedef enum logic [2:0] {
    LOAD_HI, LOAD_LO, CSUM, RUN, ERROR
  } state_t;
`else
  typedef enum logic [2:0] {
    LOAD_HI, LOAD_LO, RUN, ERROR
  } state_t;
`endif

  state_t              r_state;
  logic [7:0]          r_hi;
  logic [DEPTH_LOG2:0] r_wc;
  logic                r_cpu_rst;
  logic                r_done;
  logic                r_err;
`ifdef LOADER_CSUM_EN
  logic [7:0]          r_csum;
`endif

  logic [15:0] r_mem [DEPTH];

  logic                  w_run;
  logic                  w_xfer;
  logic                  w_full;
  logic                  w_ld_we;
  logic [15:0]           w_ld_word;
  logic [DEPTH_LOG2-1:0] w_ld_idx;
  logic [DEPTH_LOG2-1:0] w_cpu_idx;
  logic                  w_cpu_we;
  logic                  w_unused;

  assign w_run  = (r_state == RUN);
  assign w_full = (r_wc == FULL);
  assign w_xfer = bus.load_valid && bus.load_ready;

  assign bus.load_ready =
    (r_state != RUN) && (r_state != ERROR);

  assign w_ld_idx  = r_wc[DEPTH_LOG2-1:0];
  assign w_cpu_idx = bus.cpu_addr[DEPTH_LOG2-1:0];
  assign w_cpu_we  = w_run && bus.cpu_we;
  assign w_unused  = ^bus.cpu_addr[15:DEPTH_LOG2];

  // A lone high byte flagged last is padded with a zero low byte
  always_comb begin
    w_ld_we   = 1'b0;
    w_ld_word = {r_hi, bus.load_data};
    if (w_xfer && !w_full) begin
      if (r_state == LOAD_LO) begin
        w_ld_we = 1'b1;
      end else if (r_state == LOAD_HI && bus.load_last) begin
        w_ld_we   = 1'b1;
        w_ld_word = {bus.load_data, 8'h00};
      end
    end
  end

  // RAM has no reset so a reloaded program only overwrites what it covers
  always_ff @(posedge clk) begin
    if (w_ld_we)
      r_mem[w_ld_idx] <= w_ld_word;
    else if (w_cpu_we)
      r_mem[w_cpu_idx] <= bus.cpu_wdata;
  end

  assign bus.cpu_rdata = w_run ? r_mem[w_cpu_idx] : 16'h0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= LOAD_HI;
      r_hi      <= 8'h00;
      r_wc      <= '0;
      r_cpu_rst <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef LOADER_CSUM_EN
      r_csum    <= 8'h00;
`endif
    end else begin
      unique case (r_state)
        LOAD_HI: begin
          if (w_xfer) begin
`ifdef LOADER_CSUM_EN
            r_csum <= r_csum + bus.load_data;
`endif
            if (!bus.load_last) begin
              r_hi    <= bus.load_data;
              r_state <= LOAD_LO;
            end else if (w_full) begin
              r_state <= ERROR;
              r_err   <= 1'b1;
            end else begin
              r_wc <= r_wc + 1'b1;
`ifdef LOADER_CSUM_EN
              r_state <= CSUM;
`else
              r_state   <= RUN;
              r_cpu_rst <= 1'b0;
              r_done    <= 1'b1;
`endif
            end
          end
        end
        LOAD_LO: begin
          if (w_xfer) begin
`ifdef LOADER_CSUM_EN
            r_csum <= r_csum + bus.load_data;
`endif
            if (w_full) begin
              r_state <= ERROR;
              r_err   <= 1'b1;
            end else begin
              r_wc <= r_wc + 1'b1;
              if (!bus.load_last) begin
                r_state <= LOAD_HI;
              end else begin
`ifdef LOADER_CSUM_EN
                r_state <= CSUM;
`else
                r_state   <= RUN;
                r_cpu_rst <= 1'b0;
                r_done    <= 1'b1;
`endif
              end
            end
          end
        end
`ifdef LOADER_CSUM_EN
        // load_last is meaningless on the checksum byte
        CSUM: begin
          if (w_xfer) begin
            if (8'(r_csum + bus.load_data) == 8'h00) begin
              r_state   <= RUN;
              r_cpu_rst <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_state <= ERROR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        RUN, ERROR: begin
        end
        default: begin
          r_state <= ERROR;
          r_err   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cpu_rst    = r_cpu_rst;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.word_count = r_wc;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: two instances (256 and 4 words deep),
// expected results pushed by stimulus, compared at negedge by a monitor.
module tb_prog_loader;
  typedef logic [7:0]  byte_q_t [$];
  typedef logic [15:0] word_q_t [$];
  typedef struct {
    int          kind;
    int          inst;
    logic [31:0] exp;
    string       name;
  } exp_t;

  localparam int K_RD   = 0;
  localparam int K_WC   = 1;
  localparam int K_DONE = 2;
  localparam int K_ERR  = 3;
  localparam int K_CRST = 4;
  localparam int K_RDY  = 5;
`ifdef LOADER_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst8;
  logic rst2;
  always #5 clk = ~clk;

  prog_loader_if #(.DEPTH_LOG2(8)) if8 ();
  prog_loader_if #(.DEPTH_LOG2(2)) if2 ();

  prog_loader #(.DEPTH_LOG2(8)) u_dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (if8.slave)
  );

  prog_loader #(.DEPTH_LOG2(2)) u_dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (if2.slave)
  );

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [15:0] mm8  [256];
  bit          vld8 [256];
  logic [15:0] mm2  [4];
  bit          vld2 [4];

  function automatic logic [31:0] actual(input int kind, input int inst);
    logic [31:0] a;
    a = '1;
    if (inst == 0) begin
      case (kind)
        K_RD:   a = 32'(if8.cpu_rdata);
        K_WC:   a = 32'(if8.word_count);
        K_DONE: a = 32'(if8.done);
        K_ERR:  a = 32'(if8.err);
        K_CRST: a = 32'(if8.cpu_rst);
        K_RDY:  a = 32'(if8.load_ready);
        default: a = '1;
      endcase
    end else begin
      case (kind)
        K_RD:   a = 32'(if2.cpu_rdata);
        K_WC:   a = 32'(if2.word_count);
        K_DONE: a = 32'(if2.done);
        K_ERR:  a = 32'(if2.err);
        K_CRST: a = 32'(if2.cpu_rst);
        K_RDY:  a = 32'(if2.load_ready);
        default: a = '1;
      endcase
    end
    return a;
  endfunction

  initial begin : monitor
    exp_t e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        a = actual(e.kind, e.inst);
        checks++;
        if (a !== e.exp) begin
          errors++;
          $display("FAIL %s dut%0d: got %h expected %h",
                   e.name, e.inst, a, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic push(input int kind, input int inst,
                      input logic [31:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.inst = inst;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic flush();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mm_get(input int inst, input int a);
    return (inst == 0) ? mm8[a[7:0]] : mm2[a[1:0]];
  endfunction

  function automatic bit mm_vld(input int inst, input int a);
    return (inst == 0) ? vld8[a[7:0]] : vld2[a[1:0]];
  endfunction

  task automatic mm_set(input int inst, input int a, input logic [15:0] d);
    if (inst == 0) begin
      mm8[a[7:0]] = d;
      vld8[a[7:0]] = 1'b1;
    end else begin
      mm2[a[1:0]] = d;
      vld2[a[1:0]] = 1'b1;
    end
  endtask

  task automatic drive_ld(input int inst, input logic v,
                          input logic [7:0] d, input logic l);
    if (inst == 0) begin
      if8.load_valid = v; if8.load_data = d; if8.load_last = l;
    end else begin
      if2.load_valid = v; if2.load_data = d; if2.load_last = l;
    end
  endtask

  task automatic drive_cpu(input int inst, input logic [15:0] a,
                           input logic we, input logic [15:0] wd);
    if (inst == 0) begin
      if8.cpu_addr = a; if8.cpu_we = we; if8.cpu_wdata = wd;
    end else begin
      if2.cpu_addr = a; if2.cpu_we = we; if2.cpu_wdata = wd;
    end
  endtask

  task automatic set_rst(input int inst, input logic v);
    if (inst == 0) rst8 = v;
    else rst2 = v;
  endtask

  // idle cycles with load_valid low precede every offered byte
  task automatic send_byte(input int inst, input logic [7:0] d,
                           input logic l, input int idle);
    drive_ld(inst, 1'b0, 8'h00, 1'b0);
    repeat (idle) flush();
    drive_ld(inst, 1'b1, d, l);
    flush();
    drive_ld(inst, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic rd(input int inst, input int a, input logic [15:0] exp,
                    input string nm);
    logic [15:0] addr;
    addr = 16'($urandom);
    if (inst == 0) addr[7:0] = a[7:0];
    else addr[1:0] = a[1:0];
    drive_cpu(inst, addr, 1'b0, 16'h0000);
    push(K_RD, inst, 32'(exp), nm);
    flush();
  endtask

  task automatic do_reset(input int inst);
    set_rst(inst, 1'b1);
    drive_ld(inst, 1'b0, 8'h00, 1'b0);
    drive_cpu(inst, 16'h0000, 1'b0, 16'h0000);
    push(K_WC,   inst, 32'd0, "rst_word_count");
    push(K_CRST, inst, 32'd1, "rst_cpu_rst");
    push(K_DONE, inst, 32'd0, "rst_done");
    push(K_ERR,  inst, 32'd0, "rst_err");
    push(K_RDY,  inst, 32'd1, "rst_load_ready");
    push(K_RD,   inst, 32'd0, "rst_rdata");
    flush();
    set_rst(inst, 1'b0);
  endtask

  // Reference: bytes pair up big-endian, odd tail padded, stop when full
  task automatic model_words(input byte_q_t b, input int depth,
                             output word_q_t w, output bit ovf);
    w = {};
    ovf = 1'b0;
    for (int i = 0; i < b.size(); i += 2) begin
      if (w.size() == depth) begin
        ovf = 1'b1;
        break;
      end
      if (i + 1 < b.size()) w.push_back({b[i], b[i+1]});
      else w.push_back({b[i], 8'h00});
    end
  endtask

  task automatic run_load(input int inst, input byte_q_t b,
                          input int idle, input bit bad);
    word_q_t w;
    bit ovf;
    bit ok;
    int depth;
    int n;
    depth = (inst == 0) ? 256 : 4;
    model_words(b, depth, w, ovf);
    ok = !ovf && !(CSUM_ON && bad);
    n = b.size();
    for (int i = 0; i < n; i++) begin
      if (!CSUM_ON && i == n - 1 && !ovf)
        push(K_CRST, inst, 32'd1, "cpu_rst_before_last");
      send_byte(inst, b[i], (i == n - 1), idle);
    end
`ifdef LOADER_CSUM_EN
    if (!ovf) begin
      logic [7:0] sum;
      sum = 8'h00;
      foreach (b[i]) sum = sum + b[i];
      push(K_CRST, inst, 32'd1, "cpu_rst_before_csum");
      send_byte(inst, 8'(8'h00 - sum + {7'd0, bad}),
                1'($urandom_range(0, 1)), idle);
    end
`endif
    push(K_WC,   inst, 32'(w.size()), "word_count");
    push(K_DONE, inst, 32'(ok), "done");
    push(K_ERR,  inst, 32'(!ok), "err");
    push(K_CRST, inst, 32'(!ok), "cpu_rst");
    push(K_RDY,  inst, 32'd0, "load_ready_end");
    for (int i = 0; i < w.size(); i++) mm_set(inst, i, w[i]);
    flush();
    if (ok) begin
      for (int a = 0; a < depth; a++)
        if (mm_vld(inst, a)) rd(inst, a, mm_get(inst, a), "mem_word");
    end else begin
      rd(inst, 0, 16'h0000, "rdata_not_run");
    end
  endtask

  task automatic run_traffic(input int inst, input int n);
    logic [15:0] addr;
    logic [15:0] wd;
    logic we;
    int a;
    for (int k = 0; k < n; k++) begin
      addr = 16'($urandom);
      wd   = 16'($urandom);
      we   = 1'($urandom_range(0, 1));
      a = (inst == 0) ? int'(addr[7:0]) : int'(addr[1:0]);
      drive_cpu(inst, addr, we, wd);
      if (mm_vld(inst, a))
        push(K_RD, inst, 32'(mm_get(inst, a)), "run_rw");
      flush();
      if (we) mm_set(inst, a, wd);
    end
    drive_cpu(inst, 16'h0000, 1'b0, 16'h0000);
  endtask

  function automatic byte_q_t mkq(input logic [63:0] v, input int n);
    byte_q_t q;
    q = {};
    for (int i = n - 1; i >= 0; i--) q.push_back(v[i*8 +: 8]);
    return q;
  endfunction

  initial begin : stim
    byte_q_t b;
    int n;
    rst8 = 1'b1;
    rst2 = 1'b1;
    drive_ld(0, 1'b0, 8'h00, 1'b0);
    drive_ld(1, 1'b0, 8'h00, 1'b0);
    drive_cpu(0, 16'h0000, 1'b0, 16'h0000);
    drive_cpu(1, 16'h0000, 1'b0, 16'h0000);
    do_reset(0);
    do_reset(1);

    b = mkq(64'h0000_C12A_1001_7777, 6);
    run_load(0, b, 0, 1'b0);

    do_reset(0);
    b = mkq(64'h0000_0000_0012_3456, 3);
    run_load(0, b, 0, 1'b0);

    do_reset(0);
    b = mkq(64'h0000_C12A_1001_7777, 6);
    run_load(0, b, 1, 1'b0);

    drive_cpu(0, 16'h0103, 1'b1, 16'hBEEF);
    if (vld8[3]) push(K_RD, 0, 32'(mm8[3]), "same_cycle_old_data");
    flush();
    drive_cpu(0, 16'h0000, 1'b0, 16'h0000);
    mm_set(0, 3, 16'hBEEF);
    drive_cpu(0, 16'h0003, 1'b0, 16'h0000);
    push(K_RD, 0, 32'h0000BEEF, "alias_beef");
    flush();
    checks++;
    if (if8.cpu_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL alias_beef_direct: got %h", if8.cpu_rdata);
    end
    run_traffic(0, 60);

    repeat (4) begin
      do_reset(0);
      n = $urandom_range(1, 60);
      b = {};
      repeat (n) b.push_back(8'($urandom));
      run_load(0, b, $urandom_range(0, 2), 1'b0);
      run_traffic(0, 30);
    end

    do_reset(0);
    send_byte(0, 8'h01, 1'b0, 0);
    send_byte(0, 8'h02, 1'b0, 0);
    send_byte(0, 8'h03, 1'b0, 0);
    push(K_WC, 0, 32'd1, "midload_wc");
    flush();
    do_reset(0);
    b = mkq(64'h0000_0000_0000_AABB, 2);
    run_load(0, b, 0, 1'b0);

`ifdef LOADER_CSUM_EN
    do_reset(0);
    b = mkq(64'h0000_0000_0000_0102, 2);
    run_load(0, b, 0, 1'b0);
    do_reset(0);
    run_load(0, b, 0, 1'b1);
`endif

    b = {};
    repeat (10) b.push_back(8'($urandom));
    for (int i = 0; i < 8; i++) send_byte(1, b[i], 1'b0, 0);
    push(K_WC,  1, 32'd4, "ovf_wc_full");
    push(K_ERR, 1, 32'd0, "ovf_err_before");
    push(K_RDY, 1, 32'd1, "ovf_ready_before");
    for (int i = 0; i < 4; i++) mm_set(1, i, {b[2*i], b[2*i+1]});
    send_byte(1, b[8], 1'b0, 0);
    send_byte(1, b[9], 1'b0, 0);
    push(K_ERR,  1, 32'd1, "ovf_err");
    push(K_RDY,  1, 32'd0, "ovf_ready");
    push(K_CRST, 1, 32'd1, "ovf_cpu_rst");
    push(K_DONE, 1, 32'd0, "ovf_done");
    push(K_WC,   1, 32'd4, "ovf_wc");
    drive_cpu(1, 16'h0001, 1'b1, 16'hDEAD);
    push(K_RD, 1, 32'd0, "ovf_rdata_zero");
    flush();
    checks++;
    if (if2.err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_err_direct: got %b", if2.err);
    end
    checks++;
    if (if2.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL ovf_ready_direct: got %b", if2.load_ready);
    end
    drive_cpu(1, 16'h0000, 1'b0, 16'h0000);
    send_byte(1, 8'h55, 1'b1, 0);
    push(K_ERR, 1, 32'd1, "err_sticky");
    flush();
    do_reset(1);
    b = mkq(64'h0000_0000_0000_00AB, 1);
    run_load(1, b, 0, 1'b0);

    flush();
    if (checks < 12) begin
      errors++;
      $display("FAIL too few checks: %0d", checks);
    end
    if (errors != 0) $display("FAIL: %0d errors", errors);
    else $display("PASS");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of memory depth in 16-bit words.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port load_valid  input  1  loader byte present.
REQ-005 SHALL have port load_data  input  8  loader byte.
REQ-006 SHALL have port load_last  input  1  qualifies the final program byte.
REQ-007 SHALL have port load_ready  output  1  block accepts a loader byte this cycle.
REQ-008 SHALL have port cpu_addr  input  16  processor word address.
REQ-009 SHALL have port cpu_we  input  1  processor write enable.
REQ-010 SHALL have port cpu_wdata  input  16  processor write data.
REQ-011 SHALL have port cpu_rdata  output  16  processor read data.
REQ-012 SHALL have port cpu_rst  output  1  processor reset, high until the program is loaded.
REQ-013 SHALL have port done  output  1  load complete, processor running.
REQ-014 SHALL have port err  output  1  load failed; sticky until rst.
REQ-015 SHALL have port word_count  output  DEPTH_LOG2+1  words written by the loader.

Function
REQ-016 SHALL implement states LOAD_HI, LOAD_LO, CSUM (only when LOADER_CSUM_EN is defined), RUN and ERROR.
REQ-017 SHALL count a byte as transferred only on a clock edge with load_valid and load_ready both high.
REQ-018 SHALL drive load_ready high in LOAD_HI, LOAD_LO and CSUM, and low in RUN and ERROR.
REQ-019 SHALL take bytes big-endian: LOAD_HI byte is word[15:8], the following LOAD_LO byte is word[7:0].
REQ-020 SHALL write mem[word_count] and increment word_count on the LOAD_LO transfer, then return to LOAD_HI.
REQ-021 SHALL, on a LOAD_HI transfer with load_last high, write {byte, 8'h00} and increment word_count in that cycle.
REQ-022 SHALL, on any transfer with load_last high, go to CSUM if LOADER_CSUM_EN is defined, otherwise to RUN.
REQ-023 SHALL, on a word write when word_count equals 2**DEPTH_LOG2, skip the write and go to ERROR with err set.
REQ-024 SHALL drive cpu_rst from a register: high in every state except RUN, low from the first cycle in RUN.
REQ-025 SHALL drive done high only in RUN.
REQ-026 SHALL in RUN return cpu_rdata = mem[cpu_addr[DEPTH_LOG2-1:0]] combinationally with zero latency, and 16'h0000 in every other state.
REQ-027 SHALL address by cpu_addr[DEPTH_LOG2-1:0] only, so higher address bits alias (wrap-around).
REQ-028 SHALL in RUN write cpu_wdata to mem[cpu_addr[DEPTH_LOG2-1:0]] on the clock edge when cpu_we is high; a read of that address in the same cycle returns the old data.
REQ-029 SHALL ignore cpu_we outside RUN.
REQ-030 SHALL leave RUN and ERROR only through rst.

Reset
REQ-031 SHALL, while rst is high, force state LOAD_HI, word_count 0, cpu_rst 1, done 0, err 0 and the checksum accumulator 0.
REQ-032 SHALL retain memory contents across rst, with no clearing.
REQ-033 SHALL, on rst asserted mid-load, discard the partial word and restart loading at address 0.

Configuration
REQ-034 SHALL, with LOADER_CSUM_EN defined, sum all program bytes mod 256 and accept one extra byte in CSUM.
REQ-035 SHALL, in CSUM, go to RUN if the sum plus the checksum byte is 8'h00 mod 256, otherwise to ERROR with err set.
REQ-036 SHALL ignore load_last on the checksum byte.
REQ-037 SHALL, without LOADER_CSUM_EN, contain no CSUM state and no accumulator.

Verification
REQ-038 SHALL test a normal load: bytes C1,2A,10,01,77,77 with last on the final byte (macro off) -> word_count 3, mem[0..2] = C12A,1001,7777, cpu_rst falls the next cycle, done=1.
REQ-039 SHALL test an odd-length load: bytes 12,34,56 with last on 56 -> mem[1] = 5600, word_count 2.
REQ-040 SHALL test backpressure: load_valid toggled every other cycle -> identical memory contents, no bytes duplicated or dropped.
REQ-041 SHALL test overflow: DEPTH_LOG2=2, ten bytes with no last -> err=1 after the fifth word, mem[0..3] intact, load_ready=0, cpu_rst=1.
REQ-042 SHALL test RUN access: write 16'hBEEF at cpu_addr 16'h0103 (DEPTH_LOG2=8) -> a read at 16'h0003 returns BEEF.
REQ-043 SHALL test the checksum (macro on) with bytes 01,02 then checksum FD -> RUN; with checksum FE -> ERROR, err=1; a mid-load rst pulse -> word_count 0, state LOAD_HI.
